// File: rtl/cpi_pkg.sv
// Shared types for the CPI transmit path: frame-sequencer states and the
// shadow copy of the frame geometry held for the duration of a frame.
package cpi_pkg;

    localparam int unsigned CPI_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBLANK,
        ACTIVE,
        HBLANK
    } cpi_tx_state_e;

    typedef struct packed {
        logic [CPI_CNT_W-1:0] width;
        logic [CPI_CNT_W-1:0] height;
        logic [CPI_CNT_W-1:0] hblank;
        logic [CPI_CNT_W-1:0] vsync_len;
        logic [CPI_CNT_W-1:0] vblank;
    } cpi_tx_cfg_t;

    // Length fields where zero would make no sense are clamped to one.
    function automatic logic [CPI_CNT_W-1:0] cpi_at_least_one(input logic [CPI_CNT_W-1:0] v);
        return (v == '0) ? CPI_CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/cpi_tx_timegen.sv
// CPI frame timing: pixel-clock phase, frame state machine and slot/line
// counters. All state moves on the launch edge (end of the ph=1 cycle).
module cpi_tx_timegen
    import cpi_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CPI_CNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_start,
    input  logic                 i_continuous,
    input  logic [CNT_WIDTH-1:0] i_width,
    input  logic [CNT_WIDTH-1:0] i_height,
    input  logic [CNT_WIDTH-1:0] i_hblank,
    input  logic [CNT_WIDTH-1:0] i_vsync_len,
    input  logic [CNT_WIDTH-1:0] i_vblank,
    output logic                 o_ph,
    output logic                 o_launch,
    output logic                 o_pixel_slot,
    output logic                 o_frame_end,
    output logic                 o_hs_act,
    output logic                 o_vs_act,
    output logic                 o_busy
);

    cpi_tx_state_e        r_state;
    cpi_tx_state_e        w_state_nxt;
    cpi_tx_cfg_t          r_cfg;
    logic                 r_ph;
    logic                 r_start_pend;
    logic                 r_hs_act;
    logic                 r_vs_act;
    logic [CNT_WIDTH:0]   r_slot;
    logic [CNT_WIDTH:0]   w_slot_nxt;
    logic [CNT_WIDTH-1:0] r_line;
    logic [CNT_WIDTH-1:0] w_line_nxt;
    logic [CNT_WIDTH-1:0] w_hblank;
    logic [CNT_WIDTH-1:0] w_vsync_lines;
    logic [CNT_WIDTH:0]   w_line_len;
    logic                 w_cfg_ok;
    logic                 w_start_ok;
    logic                 w_launch;
    logic                 w_load_cfg;
    logic                 w_frame_end;

    assign w_cfg_ok      = (i_width != '0) && (i_height != '0);
    assign w_start_ok    = i_start && i_en && (r_state == IDLE) && w_cfg_ok;
    assign w_launch      = r_ph && i_en;
    assign w_hblank      = cpi_at_least_one(r_cfg.hblank);
    assign w_vsync_lines = cpi_at_least_one(r_cfg.vsync_len);
    assign w_line_len    = {1'b0, r_cfg.width} + {1'b0, w_hblank};

    // Next state and counters as they will be after the coming launch edge.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot + 1'b1;
        w_line_nxt  = r_line;
        w_load_cfg  = 1'b0;
        w_frame_end = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_slot_nxt = '0;
                w_line_nxt = '0;
                if ((r_start_pend || w_start_ok) && w_cfg_ok) begin
                    w_state_nxt = VSYNC;
                    w_load_cfg  = 1'b1;
                end
            end
            VSYNC: begin
                if (r_slot == w_line_len - 1'b1) begin
                    w_slot_nxt = '0;
                    if (r_line == w_vsync_lines - 1'b1) begin
                        w_line_nxt  = '0;
                        w_state_nxt = (r_cfg.vblank == '0) ? ACTIVE : VBLANK;
                    end else begin
                        w_line_nxt = r_line + 1'b1;
                    end
                end
            end
            VBLANK: begin
                if (r_slot == w_line_len - 1'b1) begin
                    w_slot_nxt = '0;
                    if (r_line == r_cfg.vblank - 1'b1) begin
                        w_line_nxt  = '0;
                        w_state_nxt = ACTIVE;
                    end else begin
                        w_line_nxt = r_line + 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (r_slot == {1'b0, r_cfg.width} - 1'b1) begin
                    w_slot_nxt  = '0;
                    w_state_nxt = HBLANK;
                end
            end
            HBLANK: begin
                if (r_slot == {1'b0, w_hblank} - 1'b1) begin
                    w_slot_nxt = '0;
                    if (r_line == r_cfg.height - 1'b1) begin
                        w_line_nxt  = '0;
                        w_frame_end = 1'b1;
                        if (i_continuous && w_cfg_ok) begin
                            w_state_nxt = VSYNC;
                            w_load_cfg  = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_line_nxt  = r_line + 1'b1;
                        w_state_nxt = ACTIVE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Phase, state register, counters and registered sync-active flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ph         <= 1'b0;
            r_state      <= IDLE;
            r_start_pend <= 1'b0;
            r_slot       <= '0;
            r_line       <= '0;
            r_hs_act     <= 1'b0;
            r_vs_act     <= 1'b0;
        end else if (!i_en) begin
            r_ph         <= 1'b0;
            r_state      <= IDLE;
            r_start_pend <= 1'b0;
            r_slot       <= '0;
            r_line       <= '0;
            r_hs_act     <= 1'b0;
            r_vs_act     <= 1'b0;
        end else begin
            r_ph <= ~r_ph;
            if (r_ph) begin
                r_state      <= w_state_nxt;
                r_slot       <= w_slot_nxt;
                r_line       <= w_line_nxt;
                r_hs_act     <= (w_state_nxt == ACTIVE);
                r_vs_act     <= (w_state_nxt == VSYNC);
                r_start_pend <= 1'b0;
            end else if (w_start_ok) begin
                // start seen in the ph=0 cycle is held until the launch edge
                r_start_pend <= 1'b1;
            end
        end
    end

    // Shadow geometry captured on every entry to VSYNC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg <= '0;
        end else if (w_launch && w_load_cfg) begin
            r_cfg.width     <= CPI_CNT_W'(i_width);
            r_cfg.height    <= CPI_CNT_W'(i_height);
            r_cfg.hblank    <= CPI_CNT_W'(i_hblank);
            r_cfg.vsync_len <= CPI_CNT_W'(i_vsync_len);
            r_cfg.vblank    <= CPI_CNT_W'(i_vblank);
        end
    end

    assign o_ph         = r_ph;
    assign o_launch     = w_launch;
    assign o_pixel_slot = w_launch && (w_state_nxt == ACTIVE);
    assign o_frame_end  = w_launch && w_frame_end;
    assign o_hs_act     = r_hs_act;
    assign o_vs_act     = r_vs_act;
    assign o_busy       = (r_state != IDLE);

endmodule

// File: rtl/cpi_tx_if.sv
// CPI transmitter top: pixel handshake with the uDMA TX stream, output data
// register, underflow/frame strobes and sync polarity on top of the timegen.
module cpi_tx_if
    import cpi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = CPI_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_start_i,
    input  logic                  cfg_continuous_i,
    input  logic [CNT_WIDTH-1:0]  cfg_width_i,
    input  logic [CNT_WIDTH-1:0]  cfg_height_i,
    input  logic [CNT_WIDTH-1:0]  cfg_hblank_i,
    input  logic [CNT_WIDTH-1:0]  cfg_vsync_len_i,
    input  logic [CNT_WIDTH-1:0]  cfg_vblank_i,
    input  logic                  cfg_vsync_pol_i,
    input  logic                  cfg_hsync_pol_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  cam_clk_o,
    output logic [DATA_WIDTH-1:0] cam_data_o,
    output logic                  cam_hsync_o,
    output logic                  cam_vsync_o,
    output logic                  busy_o,
    output logic                  frame_evt_o,
    output logic                  underflow_o
);

    logic                  w_ph;
    logic                  w_launch;
    logic                  w_pixel_slot;
    logic                  w_frame_end;
    logic                  w_hs_act;
    logic                  w_vs_act;
    logic                  w_busy;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_frame_evt;
    logic                  r_underflow;

    cpi_tx_timegen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timegen (
        .i_clk        (clk_i),
        .i_rst_n      (rstn_i),
        .i_en         (cfg_en_i),
        .i_start      (cfg_start_i),
        .i_continuous (cfg_continuous_i),
        .i_width      (cfg_width_i),
        .i_height     (cfg_height_i),
        .i_hblank     (cfg_hblank_i),
        .i_vsync_len  (cfg_vsync_len_i),
        .i_vblank     (cfg_vblank_i),
        .o_ph         (w_ph),
        .o_launch     (w_launch),
        .o_pixel_slot (w_pixel_slot),
        .o_frame_end  (w_frame_end),
        .o_hs_act     (w_hs_act),
        .o_vs_act     (w_vs_act),
        .o_busy       (w_busy)
    );

    // Output data launched with the falling pixel clock; starved slots send 0.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_data      <= '0;
            r_frame_evt <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!cfg_en_i) begin
            r_data      <= '0;
            r_frame_evt <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_frame_evt <= w_frame_end;
            r_underflow <= w_pixel_slot && !valid_i;
            if (w_launch) begin
                r_data <= (w_pixel_slot && valid_i) ? data_i : '0;
            end
        end
    end

    assign ready_o     = w_pixel_slot && valid_i;
    assign cam_clk_o   = w_ph;
    assign cam_data_o  = r_data;
    assign cam_hsync_o = w_hs_act ^ ~cfg_hsync_pol_i;
    assign cam_vsync_o = w_vs_act ^ ~cfg_vsync_pol_i;
    assign busy_o      = w_busy;
    assign frame_evt_o = r_frame_evt;
    assign underflow_o = r_underflow;

endmodule
